rr_arbiter8: RTL and testbench

- Sequential round-robin arbiter that shares one resource among 8 requesters.
- Wraps the team's 8-input priority-encode function with a rotating priority pointer, a grant FSM and an optional hold-time limit.
- Sits in front of any shared datapath; each requester holds `req` high for as long as it owns the resource.

---
 rtl/rr_arbiter8_pkg.sv | 32 +++
 rtl/rr_pick8.sv | 35 +++
 rtl/rr_arbiter8.sv | 133 +++++++++++++
 tb/tb_rr_arbiter8.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8_pkg
// Brief    : Shared constants, state encoding and lowest-set-bit encoder for
//            the 8-way round-robin arbiter.
// Revision : 1.0
// ============================================================================
package rr_arbiter8_pkg;

    localparam int N_REQ        = 8;
    localparam int ID_W         = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [ID_W-1:0] lsb_index(input logic [N_REQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick8
// Brief    : Combinational round-robin pick: lowest request strictly above
//            the last owner, falling back to the lowest request overall.
// Revision : 1.0
// ============================================================================
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    logic [N_REQ-1:0] above_last;
    logic [N_REQ-1:0] masked;
    logic [ID_W-1:0]  win_masked;
    logic [ID_W-1:0]  win_any;

    for (genvar i = 0; i < N_REQ; i++) begin : g_mask
        assign above_last[i] = (ID_W'(i) > last);
    end

    always_comb begin
        masked     = req & above_last;
        win_masked = lsb_index(masked);
        win_any    = lsb_index(req);
        winner     = (|masked) ? win_masked : win_any;
        found      = |req;
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Brief    : 8-requester round-robin arbiter with registered one-hot grant.
//            Optional hold-time preemption enabled by macro GRANT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             none
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256 || (2 ** HOLD_W) < MAX_HOLD) begin : g_bad_params
        $error("rr_arbiter8: MAX_HOLD/HOLD_W out of legal range");
    end

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             none_q, none_d;
    logic [ID_W-1:0]  last_q, last_d;
`ifdef GRANT_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    logic [ID_W-1:0] winner;
    logic            found;
    logic            take;

    // last_q always equals the current owner while in GRANT, so the pick
    // automatically demotes the owner to lowest priority.
    rr_pick8 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        none_d      = none_q;
        last_d      = last_q;
        take        = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        hold_d      = hold_q;
`endif

        unique case (state_q)
            IDLE: begin
                take = found;
            end
            GRANT: begin
                if (req[gnt_id_q]) begin
`ifdef GRANT_TIMEOUT_EN
                    if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                        take = |(req & ~gnt_q);
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
`endif
                end else if (found) begin
                    take = 1'b1;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    none_d      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            state_d     = GRANT;
            gnt_d       = N_REQ'(1) << winner;
            gnt_id_d    = winner;
            gnt_valid_d = 1'b1;
            none_d      = 1'b0;
            last_d      = winner;
`ifdef GRANT_TIMEOUT_EN
            hold_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            none_q      <= 1'b1;
            last_q      <= ID_W'(N_REQ - 1);
`ifdef GRANT_TIMEOUT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            none_q      <= none_d;
            last_q      <= last_d;
`ifdef GRANT_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign none      = none_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8
// Brief    : Directed self-checking bench for rr_arbiter8.
// Revision : 1.0
// ============================================================================
module tb_rr_arbiter8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       none;

    int checks   = 0;
    int failures = 0;

    rr_arbiter8 #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .none      (none)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output check against an expected one-hot grant (0 = idle).
    task automatic expect_gnt(input string tag, input logic [7:0] g);
        logic [7:0] id;
        id = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) id = 8'(i);
        end
        check_eq({tag, "_gnt"}, gnt, g);
        check_eq({tag, "_id"}, {5'b0, gnt_id}, id);
        check_eq({tag, "_valid"}, {7'b0, gnt_valid}, {7'b0, (g != 8'h00)});
        check_eq({tag, "_none"}, {7'b0, none}, {7'b0, (g == 8'h00)});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("inv_onehot", {7'b0, $onehot0(gnt)}, 8'h01);
            check_eq("inv_valid", {7'b0, gnt_valid}, {7'b0, |gnt});
            if (gnt != 8'h00) check_eq("inv_id", gnt, 8'h01 << gnt_id);
            else              check_eq("inv_id_idle", {5'b0, gnt_id}, 8'h00);
        end
    end

    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;

        #12;
        expect_gnt("reset", 8'h00);
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            expect_gnt("idle", 8'h00);
        end

        // Single requester: grant, hold, release.
        req = 8'h01;
        tick();
        expect_gnt("b_grant", 8'h01);
        repeat (3) begin
            tick();
            expect_gnt("b_hold", 8'h01);
        end
        req = 8'h00;
        tick();
        expect_gnt("b_release", 8'h00);

        // Asynchronous reset while granted, no clock edge in between.
        req = 8'h08;
        tick();
        expect_gnt("c_grant", 8'h08);
        #1 rst_n = 1'b0;
        #1;
        expect_gnt("c_async_rst", 8'h00);
        req = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        expect_gnt("c_after", 8'h00);

        // Full rotation, back-to-back hand-over.
        req = 8'hFF;
        tick();
        expect_gnt("d_first", 8'h01);
        for (int k = 0; k < 8; k++) begin
            cur = 8'h01 << k;
            nxt = 8'h01 << ((k + 1) % 8);
            tick();
            expect_gnt("d_hold", cur);
            req = 8'hFF & ~cur;
            tick();
            expect_gnt("d_next", nxt);
            req = 8'hFF;
        end

        // Wrap-around after owner 5, then pointer at 0.
        req = 8'h20;
        tick();
        expect_gnt("e_to5", 8'h20);
        req = 8'h00;
        tick();
        expect_gnt("e_idle", 8'h00);
        req = 8'h21;
        tick();
        expect_gnt("e_wrap", 8'h01);
        req = 8'h24;
        tick();
        expect_gnt("e_last0", 8'h04);
        req = 8'h00;
        tick();
        expect_gnt("e_idle2", 8'h00);

        // Simultaneous requests with pointer at 2.
        req = 8'h83;
        tick();
        expect_gnt("f_simul", 8'h80);

        // Lone requester holds indefinitely.
        req = 8'h01;
        tick();
        expect_gnt("g_grant", 8'h01);
        repeat (20) begin
            tick();
            expect_gnt("g_hold", 8'h01);
        end
        req = 8'h00;
        tick();
        expect_gnt("g_release", 8'h00);

`ifdef GRANT_TIMEOUT_EN
        // Two persistent requesters alternate every MAX_HOLD=4 cycles.
        req = 8'h03;
        tick();
        expect_gnt("h_grant", 8'h02);
        cur = 8'h02;
        for (int r = 0; r < 4; r++) begin
            repeat (3) begin
                tick();
                expect_gnt("h_hold", cur);
            end
            cur = (cur == 8'h02) ? 8'h01 : 8'h02;
            tick();
            expect_gnt("h_rotate", cur);
        end
        req = 8'h00;
        tick();
        expect_gnt("h_release", 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
